dev_bus_arbiter: RTL
====================

# dev_bus_arbiter

Two-master arbiter and sequencer for the processor's peripheral bus. It sits between the CPU's device port (PrAddr/PrDOut/Wen/PrDIn) and a second requester, typically a DMA or debug master, and the DEV_CNT memory-mapped devices whose interrupts feed HWInt. It grants one master at a time with round-robin fairness, decodes the device window, and drives the selected device until that device acks. It returns data, or an error on a decode miss or timeout, with a single-cycle ack.

## Interface
- DEV_CNT, 2: number of devices; must equal `CP0_DEV_CNT`.
- WIN_BASE, 24'h00007F: required value of addr[31:8] for a valid device access.
- TIMEOUT, 15: maximum ACCESS cycles without dev_ack before error; range 1..255.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req  in  1  CPU request; held until m0_ack.
- m0_addr, m0_wdata  in  32 each  CPU address and write data.
- m0_we  in  1  CPU write enable.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  error flag, valid with m0_ack.
- m0_rdata  out  32  read data, valid with m0_ack.
- m1_req, m1_addr, m1_wdata, m1_we, m1_ack, m1_err, m1_rdata: second master, same widths and semantics.
- dev_sel  out  DEV_CNT  one-hot device select.
- dev_addr  out  4  byte offset within the device window (held addr[3:0]).
- dev_wdata  out  32  held write data.
- dev_we  out  1  held write enable, qualified by dev_sel.
- dev_ack  in  DEV_CNT  per-device completion.
- dev_rdata  in  32*DEV_CNT  flattened read data; device i occupies [32i+31:32i].
- busy  out  1  high in ACCESS and RESP.

## Operation
- FSM states are IDLE, ACCESS, RESP.
- **IDLE:**
  - If any req is high, pick a master. If only one requests, grant it. If both request, grant the master not granted last.
  - Latch addr, wdata, we and master id.
  - Decode: idx = addr[7:4]. A hit requires addr[31:8]==WIN_BASE and idx<DEV_CNT.
  - On a hit, go to ACCESS with the counter cleared. On a miss, go to RESP with err=1 and rdata=0. A miss never touches the devices.
- **ACCESS:**
  - dev_sel[idx]=1; dev_addr, dev_wdata and dev_we come from the holding registers.
  - The counter increments each cycle.
  - On dev_ack[idx]: capture dev_rdata[idx] (0 on a write), set err=0, go to RESP.
  - If the counter reaches TIMEOUT with no ack: set err=1, rdata=0, go to RESP.
  - dev_ack from unselected devices is ignored.
- **RESP:**
  - Pulse mX_ack for the granted master; mX_rdata and mX_err are valid this cycle only and 0 otherwise.
  - Update last_gnt, go to IDLE.
- The request is latched at grant, so deasserting req mid-transaction does not abort; the ack is still issued.
- A req sampled high in IDLE is always a new request. Masters must drop req on the edge where they observe ack.

## Timing
- Reset values:
  - state IDLE, last_gnt=1 (m0 wins first contention), counter 0.
  - All outputs 0: m*_ack, m*_err, m*_rdata, dev_sel, dev_addr, dev_wdata, dev_we, busy.
- Reset mid-transaction aborts immediately: dev_sel drops asynchronously and no ack is ever issued.
- Latency, with req first sampled in cycle 0:
  - Device ack in the first ACCESS cycle: ACCESS in cycle 1, ack in cycle 2.
  - Device ack after k ACCESS cycles: ack in cycle k+1.
  - Decode miss: ack in cycle 1.
  - Timeout: ack in cycle TIMEOUT+1.
- dev_ack arriving in the same cycle the counter reaches TIMEOUT: the ack wins, err=0.
- Back-to-back: the minimum is one IDLE cycle between transactions. Continuous dual requests alternate m0, m1, m0, ...
- dev_* outputs are stable for the whole ACCESS phase.

## Structure
- Constants go in the shared macro header:
  - state encodings `BUS_ST_IDLE/ACCESS/RESP`;
  - `BUS_WIN_BASE`;
  - the device-index field bounds.
- One sub-module, bus_addr_dec. It is combinational: addr in, idx and hit out, parameterised by DEV_CNT and WIN_BASE.
- The FSM, counter, round-robin pointer and holding registers live in dev_bus_arbiter.

## Test plan
- **Single read:** m0 reads 0x00007F10 and device 1 acks in its first ACCESS cycle with 0xDEADBEEF. Expect dev_sel=2'b10, then m0_ack in cycle 2 with m0_rdata=0xDEADBEEF and m0_err=0.
- **Contention after reset:** m0 and m1 both request in the same cycle, all devices ack immediately. Expect grants m0, m1, m0, m1 with one IDLE cycle between each.
- **Decode miss:** m1 writes 0x00001000. Expect m1_ack in cycle 1 with m1_err=1 and dev_sel never asserted.
- **Timeout:** device 0 never acks with TIMEOUT=15. Expect the ack in cycle 16 with err=1 and rdata=0. Repeat with dev_ack arriving in the 15th ACCESS cycle; expect err=0.
- **Reset mid-ACCESS:** assert rst during an m0 write. Expect dev_sel and dev_we to drop at once and no m0_ack. After release, m1 alone requests and is granted first.

Source files
------------

// File: rtl/dev_bus_arbiter_pkg.sv
// Shared constants for the peripheral bus arbiter: FSM encodings, device window
// base, and the address fields used by the decoder.
package dev_bus_arbiter_pkg;

  localparam int          CP0_DEV_CNT  = 2;
  localparam logic [23:0] BUS_WIN_BASE = 24'h00007F;
  localparam int          BUS_IDX_LSB  = 4;
  localparam int          BUS_IDX_MSB  = 7;
  localparam int          BUS_WIN_LSB  = 8;

  typedef enum logic [1:0] {
    BUS_ST_IDLE   = 2'd0,
    BUS_ST_ACCESS = 2'd1,
    BUS_ST_RESP   = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_addr_dec.sv
// Device window decoder: extracts the device index and flags whether the
// address falls inside the window and names an existing device.
module bus_addr_dec
  import dev_bus_arbiter_pkg::*;
#(
  parameter int          DEV_CNT  = CP0_DEV_CNT,
  parameter logic [23:0] WIN_BASE = BUS_WIN_BASE
) (
  input  logic [31:0] addr,
  output logic [3:0]  idx,
  output logic        hit
);

  assign idx = addr[BUS_IDX_MSB:BUS_IDX_LSB];
  assign hit = (addr[31:BUS_WIN_LSB] == WIN_BASE) && (int'(idx) < DEV_CNT);

endmodule

// File: rtl/dev_bus_arbiter.sv
// Two-master round-robin arbiter that sequences one device access at a time
// and returns a single-cycle ack with data or error to the granted master.
module dev_bus_arbiter
  import dev_bus_arbiter_pkg::*;
#(
  parameter int          DEV_CNT  = CP0_DEV_CNT,
  parameter logic [23:0] WIN_BASE = BUS_WIN_BASE,
  parameter int          TIMEOUT  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_req,
  input  logic [31:0]            m0_addr,
  input  logic [31:0]            m0_wdata,
  input  logic                   m0_we,
  output logic                   m0_ack,
  output logic                   m0_err,
  output logic [31:0]            m0_rdata,
  input  logic                   m1_req,
  input  logic [31:0]            m1_addr,
  input  logic [31:0]            m1_wdata,
  input  logic                   m1_we,
  output logic                   m1_ack,
  output logic                   m1_err,
  output logic [31:0]            m1_rdata,
  output logic [DEV_CNT-1:0]     dev_sel,
  output logic [3:0]             dev_addr,
  output logic [31:0]            dev_wdata,
  output logic                   dev_we,
  input  logic [DEV_CNT-1:0]     dev_ack,
  input  logic [32*DEV_CNT-1:0]  dev_rdata,
  output logic                   busy
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  bus_state_e state, state_nxt;
  logic        gnt, last_gnt;
  logic [7:0]  cnt, cnt_nxt;
  logic        err_q, err_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic [3:0]  addr_q, idx_q;
  logic [31:0] wdata_q;
  logic        we_q;

  logic        sel_m1, capture, dec_hit, ack_hit, access, resp;
  logic [31:0] req_addr, req_wdata, rdata_sel;
  logic        req_we;
  logic [3:0]  dec_idx;
  logic [DEV_CNT-1:0] sel_vec;

  // m1 wins only when alone or when m0 was served last
  assign sel_m1    = m1_req && (!m0_req || !last_gnt);
  assign req_addr  = sel_m1 ? m1_addr  : m0_addr;
  assign req_wdata = sel_m1 ? m1_wdata : m0_wdata;
  assign req_we    = sel_m1 ? m1_we    : m0_we;

  bus_addr_dec #(.DEV_CNT(DEV_CNT), .WIN_BASE(WIN_BASE)) u_dec (
    .addr (req_addr),
    .idx  (dec_idx),
    .hit  (dec_hit)
  );

  always_comb begin
    sel_vec   = '0;
    rdata_sel = '0;
    for (int i = 0; i < DEV_CNT; i++) begin
      sel_vec[i] = (idx_q == 4'(i));
      if (sel_vec[i]) rdata_sel = dev_rdata[32*i +: 32];
    end
  end

  assign ack_hit = |(dev_ack & sel_vec);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err_q;
    rdata_nxt = rdata_q;
    capture   = 1'b0;
    unique case (state)
      BUS_ST_IDLE: begin
        if (m0_req || m1_req) begin
          capture = 1'b1;
          if (dec_hit) begin
            state_nxt = BUS_ST_ACCESS;
            cnt_nxt   = '0;
          end else begin
            state_nxt = BUS_ST_RESP;
            err_nxt   = 1'b1;
            rdata_nxt = '0;
          end
        end
      end
      BUS_ST_ACCESS: begin
        cnt_nxt = cnt + 8'd1;
        // an ack landing on the final counted cycle still beats the timeout
        if (ack_hit) begin
          state_nxt = BUS_ST_RESP;
          err_nxt   = 1'b0;
          rdata_nxt = we_q ? 32'd0 : rdata_sel;
        end else if (cnt == TO_LAST) begin
          state_nxt = BUS_ST_RESP;
          err_nxt   = 1'b1;
          rdata_nxt = '0;
        end
      end
      BUS_ST_RESP: state_nxt = BUS_ST_IDLE;
      default:     state_nxt = BUS_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BUS_ST_IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      cnt      <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
      if (capture) gnt <= sel_m1;
      if (state == BUS_ST_RESP) last_gnt <= gnt;
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_nxt;
    if (capture) begin
      addr_q  <= req_addr[3:0];
      wdata_q <= req_wdata;
      we_q    <= req_we;
      idx_q   <= dec_idx;
    end
  end

  assign access    = (state == BUS_ST_ACCESS);
  assign resp      = (state == BUS_ST_RESP);
  assign busy      = access || resp;
  assign dev_sel   = access ? sel_vec : '0;
  assign dev_addr  = access ? addr_q  : 4'd0;
  assign dev_wdata = access ? wdata_q : 32'd0;
  assign dev_we    = access && we_q;

  assign m0_ack    = resp && !gnt;
  assign m0_err    = m0_ack && err_q;
  assign m0_rdata  = m0_ack ? rdata_q : 32'd0;
  assign m1_ack    = resp && gnt;
  assign m1_err    = m1_ack && err_q;
  assign m1_rdata  = m1_ack ? rdata_q : 32'd0;

endmodule
